// File: rtl/riscm_pkg.sv
// Shared datapath constants and shift codes for the operand fetch and shifter stages.
package riscm_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int AW     = $clog2(NREGS);

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_e;

endpackage

// File: rtl/regfile.sv
// General register file: one synchronous write port, two asynchronous read ports.
// Define BYPASS_EN to forward a same-cycle write onto the read ports.
module regfile
   import riscm_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     ra_sel,
   input  logic [AW-1:0]     rb_sel,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] ra_raw;
   logic [DATA_W-1:0] rb_raw;

   // Decoded per-entry write; selects with no matching entry are dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NREGS; i++)
            if (wr_sel == AW'(i))
               regs[i] <= wr_data;
      end
   end

   always_comb begin
      ra_raw = '0;
      rb_raw = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (ra_sel == AW'(i))
            ra_raw = regs[i];
         if (rb_sel == AW'(i))
            rb_raw = regs[i];
      end
   end

`ifdef BYPASS_EN
   assign ra_data = (wr_en && wr_sel == ra_sel) ? wr_data : ra_raw;
   assign rb_data = (wr_en && wr_sel == rb_sel) ? wr_data : rb_raw;
`else
   assign ra_data = ra_raw;
   assign rb_data = rb_raw;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Register read stage feeding the shifter; output register behind valid/ready.
// BYPASS_EN selects write-through of same-cycle writeback into latched operands.
module operand_fetch
   import riscm_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     rn_sel,
   input  logic [AW-1:0]     rm_sel,
   input  logic [1:0]        shift_in,
   input  logic              asel,
   input  logic              bsel,
   input  logic [DATA_W-1:0] sximm5,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [1:0]        shift_out
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]        state;
   logic              accept;
   logic [DATA_W-1:0] rn_data;
   logic [DATA_W-1:0] rm_data;
   logic [DATA_W-1:0] a_nxt;
   logic [DATA_W-1:0] b_nxt;

   regfile u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .ra_sel  (rn_sel),
      .rb_sel  (rm_sel),
      .ra_data (rn_data),
      .rb_data (rm_data)
   );

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   assign a_nxt = asel ? '0 : rn_data;
   assign b_nxt = bsel ? sximm5 : rm_data;

   // Outputs only load on accept, so a stalled op never sees later writes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= EMPTY;
         a_out     <= '0;
         b_out     <= '0;
         shift_out <= SH_NONE;
      end else if (accept) begin
         state     <= FULL;
         a_out     <= a_nxt;
         b_out     <= b_nxt;
         shift_out <= shift_in;
      end else if (out_ready) begin
         state     <= EMPTY;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table plus handshake corner sequences.
module tb_operand_fetch;
   import riscm_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     rn_sel;
   logic [AW-1:0]     rm_sel;
   logic [1:0]        shift_in;
   logic              asel;
   logic              bsel;
   logic [DATA_W-1:0] sximm5;
   logic              wr_en;
   logic [AW-1:0]     wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] a_out;
   logic [DATA_W-1:0] b_out;
   logic [1:0]        shift_out;

   operand_fetch dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rn_sel    (rn_sel),
      .rm_sel    (rm_sel),
      .shift_in  (shift_in),
      .asel      (asel),
      .bsel      (bsel),
      .sximm5    (sximm5),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .shift_out (shift_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              we;
      logic [2:0]        ws;
      logic [15:0]       wd;
      logic [2:0]        rn;
      logic [2:0]        rm;
      logic [1:0]        sh;
      logic              as;
      logic              bs;
      logic [15:0]       imm;
      logic [15:0]       ea;
      logic [15:0]       eb;
      logic [1:0]        esh;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  sh;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t cur;
   vec_t vt[10];

`ifdef BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      wr_en    = 1'b0;
      wr_sel   = '0;
      wr_data  = '0;
      rn_sel   = '0;
      rm_sel   = '0;
      shift_in = SH_NONE;
      asel     = 1'b0;
      bsel     = 1'b0;
      sximm5   = '0;
   endtask

   task automatic set_op(input logic [2:0] rn, input logic [2:0] rm,
                         input logic [1:0] sh, input logic as,
                         input logic bs, input logic [15:0] imm);
      in_valid = 1'b1;
      rn_sel   = rn;
      rm_sel   = rm;
      shift_in = sh;
      asel     = as;
      bsel     = bs;
      sximm5   = imm;
   endtask

   // Score one clock: pop on output transfer, push on input accept.
   task automatic step();
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_a", 32'(a_out), 32'(e.a));
            chk("sb_b", 32'(b_out), 32'(e.b));
            chk("sb_sh", 32'(shift_out), 32'(e.sh));
         end
      end
      if (in_valid && in_ready)
         sb.push_back(cur);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      sb.delete();
   endtask

   initial begin
      logic [15:0] a_hold;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      idle();

      // Dirty the state before reset so clearing is observable.
      wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'hDEAD;
      set_op(3'd4, 3'd4, SH_ASR, 1'b0, 1'b0, 16'h0);
      @(posedge clk); #1;
      idle();
      do_reset();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_a", 32'(a_out), 32'd0);
      chk("rst_b", 32'(b_out), 32'd0);
      chk("rst_sh", 32'(shift_out), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      vt[0] = '{0, 0, 16'h0000, 0, 4, SH_NONE, 0, 0, 16'h0000,
                16'h0000, 16'h0000, SH_NONE};
      vt[1] = '{1, 3, 16'h00F0, 5, 6, SH_LSL, 0, 0, 16'h0000,
                16'h0000, 16'h0000, SH_LSL};
      vt[2] = '{0, 0, 16'h0000, 3, 3, SH_LSR, 0, 0, 16'h0000,
                16'h00F0, 16'h00F0, SH_LSR};
      vt[3] = '{0, 0, 16'h0000, 3, 3, SH_ASR, 1, 1, 16'hFFFB,
                16'h0000, 16'hFFFB, SH_ASR};
      vt[4] = '{1, 2, 16'h1234, 2, 3, SH_NONE, 0, 0, 16'h0000,
                BYP ? 16'h1234 : 16'h0000, 16'h00F0, SH_NONE};
      vt[5] = '{1, 7, 16'hABCD, 2, 7, SH_LSR, 0, 0, 16'h0000,
                16'h1234, BYP ? 16'hABCD : 16'h0000, SH_LSR};
      vt[6] = '{0, 0, 16'h0000, 7, 2, SH_LSL, 0, 1, 16'h000A,
                16'hABCD, 16'h000A, SH_LSL};
      vt[7] = '{1, 1, 16'h5555, 1, 1, SH_ASR, 1, 0, 16'h0000,
                16'h0000, BYP ? 16'h5555 : 16'h0000, SH_ASR};
      vt[8] = '{0, 0, 16'h0000, 1, 7, SH_LSL, 0, 0, 16'h0000,
                16'h5555, 16'hABCD, SH_LSL};
      vt[9] = '{1, 7, 16'h0000, 7, 0, SH_NONE, 0, 0, 16'h0000,
                BYP ? 16'h0000 : 16'hABCD, 16'h0000, SH_NONE};

      // Back-to-back issue with downstream always ready.
      for (int i = 0; i < 10; i++) begin
         wr_en   = vt[i].we;
         wr_sel  = vt[i].ws;
         wr_data = vt[i].wd;
         set_op(vt[i].rn, vt[i].rm, vt[i].sh, vt[i].as, vt[i].bs, vt[i].imm);
         cur = '{vt[i].ea, vt[i].eb, vt[i].esh};
         if (i > 0)
            chk("b2b_ready", 32'(in_ready), 32'd1);
         step();
         chk("b2b_valid", 32'(out_valid), 32'd1);
      end
      idle();
      step();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_empty", 32'(sb.size()), 32'd0);

      // Stall: held op must not change or see a write to its source.
      wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h0404;
      step();
      idle();
      out_ready = 1'b0;
      set_op(3'd4, 3'd4, SH_LSR, 1'b0, 1'b0, 16'h0);
      cur = '{16'h0404, 16'h0404, SH_LSR};
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      a_hold = a_out;
      chk("stall_a0", 32'(a_hold), 32'h0404);
      set_op(3'd5, 3'd6, SH_ASR, 1'b1, 1'b1, 16'h7777);
      for (int i = 0; i < 3; i++) begin
         wr_en = (i == 0); wr_sel = 3'd4; wr_data = 16'hFFFF;
         chk("stall_ready", 32'(in_ready), 32'd0);
         step();
         chk("stall_a", 32'(a_out), 32'h0404);
         chk("stall_b", 32'(b_out), 32'h0404);
         chk("stall_sh", 32'(shift_out), 32'(SH_LSR));
         chk("stall_vld", 32'(out_valid), 32'd1);
      end
      idle();
      out_ready = 1'b1;
      step();
      chk("unstall_valid", 32'(out_valid), 32'd0);
      set_op(3'd4, 3'd0, SH_NONE, 1'b0, 1'b0, 16'h0);
      cur = '{16'hFFFF, 16'h0000, SH_NONE};
      step();
      idle();
      step();

      // Reset with an op held: op dropped, registers cleared.
      out_ready = 1'b0;
      set_op(3'd4, 3'd2, SH_LSL, 1'b0, 1'b0, 16'h0);
      cur = '{16'hFFFF, 16'h1234, SH_LSL};
      step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      idle();
      do_reset();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_a", 32'(a_out), 32'd0);
      out_ready = 1'b1;
      set_op(3'd4, 3'd2, SH_LSR, 1'b0, 1'b0, 16'h0);
      cur = '{16'h0000, 16'h0000, SH_LSR};
      step();
      idle();
      for (int i = 0; i < 10 && sb.size() != 0; i++)
         step();
      chk("final_empty", 32'(sb.size()), 32'd0);
      chk("final_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
